// File: rtl/raster_walker_if.sv
// Triangle-in / pixel-out handshake bundle for raster_walker.
// master: triangle source and fragment sink; slave: the walker itself.
interface raster_walker_if;
  logic        tri_valid;
  logic        tri_ready;
  logic [9:0]  x0, y0, x1, y1, x2, y2;
  logic        px_valid;
  logic        px_ready;
  logic [9:0]  px_x, px_y;
  logic [19:0] ua, va, wa;
  logic [19:0] a;
  logic        visible;
  logic        px_last;

  modport master (
    output tri_valid, x0, y0, x1, y1, x2, y2, px_ready,
    input  tri_ready, px_valid, px_x, px_y, ua, va, wa, a, visible, px_last
  );

  modport slave (
    input  tri_valid, x0, y0, x1, y1, x2, y2, px_ready,
    output tri_ready, px_valid, px_x, px_y, ua, va, wa, a, visible, px_last
  );
endinterface

// File: rtl/raster_walker.sv
// Triangle raster walker: row-major scan with incrementally stepped edge functions.
// Define RASTER_WALKER_BBOX_EN to walk only the vertex bounding box (clamped to the
// frame); without it the whole H_RES x V_RES frame is walked for every triangle.
module raster_walker #(
  parameter int unsigned H_RES = 640,
  parameter int unsigned V_RES = 480
) (
  input logic            clk,
  input logic            rst_n,
  raster_walker_if.slave bus
);

  localparam logic [9:0] XLast = 10'(H_RES - 1);
  localparam logic [9:0] YLast = 10'(V_RES - 1);

  typedef enum logic [1:0] {StIdle, StSetup, StWalk} state_e;

  function automatic logic signed [10:0] diff(input logic [9:0] p, input logic [9:0] q);
    return $signed({1'b0, p}) - $signed({1'b0, q});
  endfunction

  function automatic logic signed [21:0] sext(input logic signed [10:0] v);
    return {{11{v[10]}}, v};
  endfunction

  // Edge function of directed edge i->j evaluated at (px,py); 22 bits hold it exactly.
  function automatic logic signed [21:0] edge_fn(input logic [9:0] xi, input logic [9:0] yi,
                                                 input logic [9:0] xj, input logic [9:0] yj,
                                                 input logic [9:0] px, input logic [9:0] py);
    return sext(diff(xj, xi)) * sext(diff(py, yi)) - sext(diff(yj, yi)) * sext(diff(px, xi));
  endfunction

`ifdef RASTER_WALKER_BBOX_EN
  function automatic logic [9:0] min3(input logic [9:0] p, input logic [9:0] q,
                                      input logic [9:0] r);
    logic [9:0] m;
    m = (p < q) ? p : q;
    return (m < r) ? m : r;
  endfunction

  function automatic logic [9:0] max3(input logic [9:0] p, input logic [9:0] q,
                                      input logic [9:0] r);
    logic [9:0] m;
    m = (p > q) ? p : q;
    return (m > r) ? m : r;
  endfunction

  function automatic logic [9:0] clamp(input logic [9:0] v, input logic [9:0] lim);
    return (v > lim) ? lim : v;
  endfunction
`endif

  state_e            state_q, state_d;
  logic [9:0]        vx0_q, vy0_q, vx1_q, vy1_q, vx2_q, vy2_q;
  logic [9:0]        vx0_d, vy0_d, vx1_d, vy1_d, vx2_d, vy2_d;
  logic [9:0]        x_min_q, x_max_q, y_min_q, y_max_q;
  logic [9:0]        x_min_d, x_max_d, y_min_d, y_max_d;
  logic [9:0]        px_x_q, px_y_q, px_x_d, px_y_d;
  logic signed [21:0] e12_q, e20_q, e01_q, e12_d, e20_d, e01_d;
  logic signed [21:0] r12_q, r20_q, r01_q, r12_d, r20_d, r01_d;
  logic [19:0]       a_q, a_d;
  logic              valid_q, valid_d, last_q, last_d, vis_q, vis_d;

  logic signed [21:0] sx12, sx20, sx01, sy12, sy20, sy01;
  logic signed [21:0] area, o12, o20, o01, ne12, ne20, ne01;
  logic [9:0]        nx_x, nx_y;

  // Per-pixel x step and per-row y step of each edge function
  assign sx12 = sext(diff(vy1_q, vy2_q));
  assign sx20 = sext(diff(vy2_q, vy0_q));
  assign sx01 = sext(diff(vy0_q, vy1_q));
  assign sy12 = sext(diff(vx2_q, vx1_q));
  assign sy20 = sext(diff(vx0_q, vx2_q));
  assign sy01 = sext(diff(vx1_q, vx0_q));

  // Next-state: accept, one-cycle setup multiply, then incremental walk
  always_comb begin
    state_d = state_q;
    vx0_d = vx0_q; vy0_d = vy0_q; vx1_d = vx1_q; vy1_d = vy1_q; vx2_d = vx2_q; vy2_d = vy2_q;
    x_min_d = x_min_q; x_max_d = x_max_q; y_min_d = y_min_q; y_max_d = y_max_q;
    px_x_d = px_x_q; px_y_d = px_y_q;
    e12_d = e12_q; e20_d = e20_q; e01_d = e01_q;
    r12_d = r12_q; r20_d = r20_q; r01_d = r01_q;
    a_d = a_q; valid_d = valid_q; last_d = last_q; vis_d = vis_q;

    area = edge_fn(vx1_q, vy1_q, vx2_q, vy2_q, vx0_q, vy0_q);
    o12  = edge_fn(vx1_q, vy1_q, vx2_q, vy2_q, x_min_q, y_min_q);
    o20  = edge_fn(vx2_q, vy2_q, vx0_q, vy0_q, x_min_q, y_min_q);
    o01  = edge_fn(vx0_q, vy0_q, vx1_q, vy1_q, x_min_q, y_min_q);

    // Candidate next pixel: wrap to a new row from the saved row-start values
    nx_x = px_x_q + 10'd1;
    nx_y = px_y_q;
    ne12 = e12_q + sx12;
    ne20 = e20_q + sx20;
    ne01 = e01_q + sx01;
    if (px_x_q == x_max_q) begin
      nx_x = x_min_q;
      nx_y = px_y_q + 10'd1;
      ne12 = r12_q + sy12;
      ne20 = r20_q + sy20;
      ne01 = r01_q + sy01;
    end

    unique case (state_q)
      StIdle: begin
        if (bus.tri_valid) begin
          vx0_d = bus.x0; vy0_d = bus.y0;
          vx1_d = bus.x1; vy1_d = bus.y1;
          vx2_d = bus.x2; vy2_d = bus.y2;
`ifdef RASTER_WALKER_BBOX_EN
          // Min is clamped too so an off-screen triangle cannot leave x_min > x_max
          x_min_d = clamp(min3(bus.x0, bus.x1, bus.x2), XLast);
          x_max_d = clamp(max3(bus.x0, bus.x1, bus.x2), XLast);
          y_min_d = clamp(min3(bus.y0, bus.y1, bus.y2), YLast);
          y_max_d = clamp(max3(bus.y0, bus.y1, bus.y2), YLast);
`else
          x_min_d = '0;
          x_max_d = XLast;
          y_min_d = '0;
          y_max_d = YLast;
`endif
          state_d = StSetup;
        end
      end
      StSetup: begin
        a_d = area[19:0];
        if (area[21] || (area == '0)) begin
          state_d = StIdle;
        end else begin
          state_d = StWalk;
          px_x_d  = x_min_q;
          px_y_d  = y_min_q;
          e12_d   = o12; e20_d = o20; e01_d = o01;
          r12_d   = o12; r20_d = o20; r01_d = o01;
          valid_d = 1'b1;
          last_d  = (x_min_q == x_max_q) && (y_min_q == y_max_q);
          vis_d   = ~o12[21] & ~o20[21] & ~o01[21];
        end
      end
      StWalk: begin
        if (valid_q && bus.px_ready) begin
          if (last_q) begin
            state_d = StIdle;
            valid_d = 1'b0;
            last_d  = 1'b0;
          end else begin
            px_x_d = nx_x;
            px_y_d = nx_y;
            e12_d  = ne12; e20_d = ne20; e01_d = ne01;
            if (px_x_q == x_max_q) begin
              r12_d = ne12; r20_d = ne20; r01_d = ne01;
            end
            last_d = (nx_x == x_max_q) && (nx_y == y_max_q);
            vis_d  = ~ne12[21] & ~ne20[21] & ~ne01[21];
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      vx0_q <= '0; vy0_q <= '0; vx1_q <= '0; vy1_q <= '0; vx2_q <= '0; vy2_q <= '0;
      x_min_q <= '0; x_max_q <= '0; y_min_q <= '0; y_max_q <= '0;
      px_x_q <= '0; px_y_q <= '0;
      e12_q <= '0; e20_q <= '0; e01_q <= '0;
      r12_q <= '0; r20_q <= '0; r01_q <= '0;
      a_q <= '0; valid_q <= 1'b0; last_q <= 1'b0; vis_q <= 1'b0;
    end else begin
      state_q <= state_d;
      vx0_q <= vx0_d; vy0_q <= vy0_d; vx1_q <= vx1_d; vy1_q <= vy1_d;
      vx2_q <= vx2_d; vy2_q <= vy2_d;
      x_min_q <= x_min_d; x_max_q <= x_max_d; y_min_q <= y_min_d; y_max_q <= y_max_d;
      px_x_q <= px_x_d; px_y_q <= px_y_d;
      e12_q <= e12_d; e20_q <= e20_d; e01_q <= e01_d;
      r12_q <= r12_d; r20_q <= r20_d; r01_q <= r01_d;
      a_q <= a_d; valid_q <= valid_d; last_q <= last_d; vis_q <= vis_d;
    end
  end

  assign bus.tri_ready = (state_q == StIdle);
  assign bus.px_valid  = valid_q;
  assign bus.px_last   = last_q;
  assign bus.px_x      = px_x_q;
  assign bus.px_y      = px_y_q;
  assign bus.ua        = e12_q[19:0];
  assign bus.va        = e20_q[19:0];
  assign bus.wa        = e01_q[19:0];
  assign bus.a         = a_q;
  assign bus.visible   = vis_q;

endmodule

// File: tb/tb_raster_walker.sv
// Self-checking bench for raster_walker on a reduced 32x24 frame.
// Reference model evaluates every edge function by direct multiplication per pixel.
module tb_raster_walker;
  localparam int H = 32;
  localparam int V = 24;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  raster_walker_if bus();

  raster_walker #(.H_RES(H), .V_RES(V)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [9:0]  x;
    logic [9:0]  y;
    logic [19:0] ua;
    logic [19:0] va;
    logic [19:0] wa;
    logic        vis;
    logic        last;
  } pix_t;

  typedef struct {
    int x0, y0, x1, y1, x2, y2;
    logic [19:0] exp_a;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  pix_t        exp_q[$];
  logic [19:0] model_a;
  int          max_x_seen = 0;
  pix_t        p22, p52;
  bit          seen22, seen52;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int edge_val(input int xi, input int yi, input int xj, input int yj,
                                  input int px, input int py);
    return (xj - xi) * (py - yi) - (yj - yi) * (px - xi);
  endfunction

  function automatic int imin(input int p, input int q);
    return (p < q) ? p : q;
  endfunction

  function automatic int imax(input int p, input int q);
    return (p > q) ? p : q;
  endfunction

  // Expected pixel stream for one triangle, in walk order
  task automatic build_model(input vec_t t);
    int xmin, xmax, ymin, ymax, ar;
    exp_q.delete();
    ar = edge_val(t.x1, t.y1, t.x2, t.y2, t.x0, t.y0);
    model_a = 20'(ar);
`ifdef RASTER_WALKER_BBOX_EN
    xmin = imin(imin(t.x0, t.x1), t.x2);
    xmax = imin(imax(imax(t.x0, t.x1), t.x2), H - 1);
    ymin = imin(imin(t.y0, t.y1), t.y2);
    ymax = imin(imax(imax(t.y0, t.y1), t.y2), V - 1);
`else
    xmin = 0; xmax = H - 1;
    ymin = 0; ymax = V - 1;
`endif
    if (ar <= 0) return;
    for (int y = ymin; y <= ymax; y++) begin
      for (int x = xmin; x <= xmax; x++) begin
        pix_t p;
        int   e12, e20, e01;
        e12 = edge_val(t.x1, t.y1, t.x2, t.y2, x, y);
        e20 = edge_val(t.x2, t.y2, t.x0, t.y0, x, y);
        e01 = edge_val(t.x0, t.y0, t.x1, t.y1, x, y);
        p.x    = 10'(x);
        p.y    = 10'(y);
        p.ua   = 20'(e12);
        p.va   = 20'(e20);
        p.wa   = 20'(e01);
        p.vis  = (e12 >= 0) && (e20 >= 0) && (e01 >= 0);
        p.last = (x == xmax) && (y == ymax);
        exp_q.push_back(p);
      end
    end
  endtask

  function automatic pix_t sample();
    pix_t p;
    p.x = bus.px_x; p.y = bus.px_y;
    p.ua = bus.ua; p.va = bus.va; p.wa = bus.wa;
    p.vis = bus.visible; p.last = bus.px_last;
    return p;
  endfunction

  // Starts and ends at a falling edge; ends two cycles after acceptance
  task automatic accept(input vec_t t);
    chk("tri_ready_idle", 96'(bus.tri_ready), 96'(1));
    bus.tri_valid = 1'b1;
    bus.x0 = 10'(t.x0); bus.y0 = 10'(t.y0);
    bus.x1 = 10'(t.x1); bus.y1 = 10'(t.y1);
    bus.x2 = 10'(t.x2); bus.y2 = 10'(t.y2);
    @(negedge clk);
    bus.tri_valid = 1'b0;
    chk("tri_ready_setup", 96'(bus.tri_ready), 96'(0));
    @(negedge clk);
  endtask

  task automatic walk(input int pct);
    pix_t cur, held;
    bit   stalled;
    int   cyc, budget;
    if (exp_q.size() == 0) begin
      chk("degenerate_no_valid", 96'(bus.px_valid), 96'(0));
      chk("degenerate_ready", 96'(bus.tri_ready), 96'(1));
      repeat (2) begin
        @(negedge clk);
        chk("degenerate_stays_idle", 96'(bus.px_valid), 96'(0));
      end
      return;
    end
    chk("first_px_valid", 96'(bus.px_valid), 96'(1));
    stalled = 1'b0;
    cyc = 0;
    budget = exp_q.size() * 8 + 50;
    while (exp_q.size() > 0 && cyc < budget) begin
      if (!bus.px_valid) begin
        chk("px_valid_mid_walk", 96'(bus.px_valid), 96'(1));
        break;
      end
      cur = sample();
      if (stalled) chk("stall_hold", 96'(cur), 96'(held));
      bus.px_ready = ($urandom_range(99) < pct);
      if (bus.px_ready) begin
        chk("pixel", 96'(cur), 96'(exp_q.pop_front()));
        stalled = 1'b0;
        if (int'(cur.x) > max_x_seen) max_x_seen = int'(cur.x);
        if (cur.x == 10'd2 && cur.y == 10'd2) begin p22 = cur; seen22 = 1'b1; end
        if (cur.x == 10'd5 && cur.y == 10'd2) begin p52 = cur; seen52 = 1'b1; end
      end else begin
        stalled = 1'b1;
        held = cur;
      end
      @(negedge clk);
      cyc++;
    end
    bus.px_ready = 1'b0;
    chk("walk_remaining", 96'(exp_q.size()), 96'(0));
    chk("idle_after_last", 96'(bus.tri_ready), 96'(1));
    chk("valid_after_last", 96'(bus.px_valid), 96'(0));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: simulation still running at %0t, expected completion", $time);
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vecs[5];
    vec_t r, busy;
    pix_t snap;
    vecs[0] = '{2, 0, 4, 4, 0, 4, 20'd16};
    vecs[1] = '{0, 0, 1, 1, 2, 2, 20'd0};
    vecs[2] = '{2, 0, 0, 4, 4, 4, 20'hFFFF0};
    vecs[3] = '{0, 0, 10, 0, 0, 10, 20'd100};
    vecs[4] = '{5, 5, 1023, 10, 10, 20, 20'd15245};
    busy    = '{7, 7, 9, 9, 3, 9, 20'd0};

    bus.tri_valid = 1'b0; bus.px_ready = 1'b0;
    bus.x0 = '0; bus.y0 = '0; bus.x1 = '0; bus.y1 = '0; bus.x2 = '0; bus.y2 = '0;
    seen22 = 1'b0; seen52 = 1'b0;

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_px_valid", 96'(bus.px_valid), 96'(0));
    chk("rst_px_last", 96'(bus.px_last), 96'(0));
    chk("rst_pixel", 96'(sample()), 96'(0));
    chk("rst_a", 96'(bus.a), 96'(0));
    rst_n = 1'b1;
    @(negedge clk);
    chk("tri_ready_after_rst", 96'(bus.tri_ready), 96'(1));

    // Directed table
    for (int i = 0; i < 5; i++) begin
      build_model(vecs[i]);
      accept(vecs[i]);
      chk("area", 96'(bus.a), 96'(vecs[i].exp_a));
      walk(75);
      if (i == 0) begin
        chk("seen_2_2", 96'(seen22), 96'(1));
        chk("ua_2_2", 96'(p22.ua), 96'(8));
        chk("va_2_2", 96'(p22.va), 96'(4));
        chk("wa_2_2", 96'(p22.wa), 96'(4));
        chk("vis_2_2", 96'(p22.vis), 96'(1));
`ifndef RASTER_WALKER_BBOX_EN
        chk("seen_5_2", 96'(seen52), 96'(1));
        chk("vis_5_2", 96'(p52.vis), 96'(0));
`endif
      end
    end

    // Stall at (1,0) with a competing triangle offered, then reset mid-walk
    build_model(vecs[0]);
    accept(vecs[0]);
    chk("seq_pix0", 96'(sample()), 96'(exp_q[0]));
    bus.px_ready = 1'b1;
    @(negedge clk);
    chk("seq_pix1", 96'(sample()), 96'(exp_q[1]));
    snap = sample();
    bus.px_ready = 1'b0;
    bus.tri_valid = 1'b1;
    bus.x0 = 10'(busy.x0); bus.y0 = 10'(busy.y0);
    bus.x1 = 10'(busy.x1); bus.y1 = 10'(busy.y1);
    bus.x2 = 10'(busy.x2); bus.y2 = 10'(busy.y2);
    repeat (3) begin
      @(negedge clk);
      chk("stall_3_hold", 96'(sample()), 96'(snap));
      chk("stall_valid", 96'(bus.px_valid), 96'(1));
      chk("busy_tri_ready", 96'(bus.tri_ready), 96'(0));
    end
    bus.tri_valid = 1'b0;
    bus.px_ready = 1'b1;
    @(negedge clk);
    bus.px_ready = 1'b0;
    chk("resume_pix2", 96'(sample()), 96'(exp_q[2]));
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_px_valid", 96'(bus.px_valid), 96'(0));
    chk("abort_tri_ready", 96'(bus.tri_ready), 96'(1));
    chk("abort_pixel", 96'(sample()), 96'(0));
    chk("abort_a", 96'(bus.a), 96'(0));
    @(negedge clk);
    chk("abort_stays_idle", 96'(bus.px_valid), 96'(0));
    build_model(vecs[3]);
    accept(vecs[3]);
    chk("restart_area", 96'(bus.a), 96'(vecs[3].exp_a));
    walk(100);

    // Random triangles against the model
    for (int n = 0; n < 6; n++) begin
      r.x0 = int'($urandom_range(H - 1)); r.y0 = int'($urandom_range(V - 1));
      r.x1 = int'($urandom_range(H - 1)); r.y1 = int'($urandom_range(V - 1));
      r.x2 = int'($urandom_range(H - 1)); r.y2 = int'($urandom_range(V - 1));
      r.exp_a = '0;
      build_model(r);
      accept(r);
      chk("area_rand", 96'(bus.a), 96'(model_a));
      walk(int'($urandom_range(50, 100)));
    end

    chk("max_px_x", 96'(max_x_seen), 96'(H - 1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/raster_walker.md
RASTER_WALKER -- requirements
Module: raster_walker

Interface
REQ-001 Parameter H_RES, default 640, horizontal pixel count of the frame.
REQ-002 Parameter V_RES, default 480, vertical line count of the frame.
REQ-003 One clock; reset is synchronous and active-low.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst_n  input  1  synchronous active-low reset.
REQ-006 tri_valid  input  1  triangle descriptor valid.
REQ-007 tri_ready  output  1  walker idle and able to accept a triangle.
REQ-008 x0,y0,x1,y1,x2,y2  input  10 each  unsigned vertex screen coordinates.
REQ-009 px_valid  output  1  pixel output valid.
REQ-010 px_ready  input  1  downstream fragment stage accepts pixel.
REQ-011 px_x / px_y  output  10 / 10  current pixel coordinate.
REQ-012 ua, va, wa  output  20 each  edge-function values, low 20 bits, for vertices v0, v1, v2.
REQ-013 a  output  20  doubled triangle area, low 20 bits.
REQ-014 visible  output  1  pixel inside triangle.
REQ-015 px_last  output  1  asserted with the final pixel of the walk.

Function
REQ-016 States: IDLE, SETUP, WALK; tri_ready SHALL equal (state==IDLE).
REQ-017 IDLE->SETUP on tri_valid&&tri_ready; vertices latched on that edge.
REQ-018 SETUP (1 cycle) computes 22-bit signed edge values at walk origin: E12(p)=(x2-x1)(py-y1)-(y2-y1)(px-x1), E20 and E01 cyclically; a=E12(v0).
REQ-019 SETUP->IDLE when a<=0 (degenerate or clockwise); no pixel emitted.
REQ-020 SETUP->WALK otherwise; first px_valid two cycles after triangle acceptance.
REQ-021 Walk order row-major: x increments to x_max, then x=x_min, y increments; origin (x_min,y_min).
REQ-022 Edge values updated incrementally only: step x adds (y_i-y_j); new row adds (x_j-x_i) to saved row-start value; no per-pixel multiply.
REQ-023 Pixel advances only on px_valid&&px_ready; all px_* outputs held stable otherwise.
REQ-024 visible = all three edge values >=0 (top-left rule not applied).
REQ-025 px_last=1 exactly at (x_max,y_max); its handshake returns state to IDLE next cycle.
REQ-026 New tri_valid during SETUP/WALK ignored (tri_ready=0).

Reset
REQ-027 rst_n=0 at a rising edge SHALL force IDLE, px_valid=0, px_last=0, px_x=px_y=0, ua=va=wa=a=0, visible=0.
REQ-028 tri_ready=1 first cycle after rst_n rises.
REQ-029 Reset mid-walk aborts immediately; no further pixels; latched triangle discarded.

Configuration
REQ-030 Macro RASTER_WALKER_BBOX_EN.
REQ-031 Defined: x_min/x_max/y_min/y_max = vertex bounding box, max clamped to H_RES-1/V_RES-1.
REQ-032 Undefined: walk covers full frame, (0,0) to (H_RES-1,V_RES-1), H_RES*V_RES pixels.

Verification
REQ-033 BBOX_EN, v0=(2,0),v1=(4,4),v2=(0,4) -> a=16; 25 pixels (0,0)..(4,4); at (2,2) ua=8,va=4,wa=4,visible=1; px_last only at (4,4).
REQ-034 Same triangle, BBOX_EN undefined -> 307200 pixels, px_last at (639,479), visible=0 at (5,2).
REQ-035 px_ready low 3 cycles while at (1,0) -> px_x,px_y,ua,va,wa,visible unchanged; walk resumes at (2,0).
REQ-036 Collinear (0,0),(1,1),(2,2) -> a=0, px_valid never asserted, tri_ready=1 two cycles after accept.
REQ-037 rst_n low one cycle mid-walk -> next cycle px_valid=0, tri_ready=1; new triangle restarts at its origin.
REQ-038 Vertex x=1023 with BBOX_EN -> x_max=639, no px_x>=640.
